// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage multi-cycle divider: state encodings,
// handshake constants and a conditional two's-complement helper.
`default_nettype none

package div_pkg;

  localparam int DivWidth = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [DivWidth-1:0] ZeroWord = 32'h0;

  function automatic logic [DivWidth-1:0] neg_if(input logic [DivWidth-1:0] v,
                                                 input logic en);
    return en ? (~v + DivWidth'(1)) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
`default_nettype none

interface div_if #(
  parameter int WIDTH = 32
) ();

  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );

endinterface

`default_nettype wire

// File: rtl/div.sv
// Radix-2 restoring 32-bit divider, one quotient bit per cycle; result is
// {remainder, quotient}, divide-by-zero short-circuits to an all-zero result.
`default_nettype none

module div
  import div_pkg::*;
#(
  parameter int WIDTH = DivWidth
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int CntW = $clog2(WIDTH + 1);
  localparam int DvdW = 2 * WIDTH + 1;

  div_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DvdW-1:0]       dividend_q, dividend_d;
  logic [WIDTH-1:0]      divisor_q, divisor_d;
  logic                  neg_quot_q, neg_quot_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]    result_q, result_d;
  logic                  ready_q, ready_d;

  logic                  go;
  logic                  op1_neg;
  logic                  op2_neg;
  logic [WIDTH-1:0]      op1_abs;
  logic [WIDTH-1:0]      op2_abs;
  logic [WIDTH:0]        trial;
  logic [DvdW-1:0]       step;
  logic                  cnt_done;
  logic [WIDTH-1:0]      quot_final;
  logic [WIDTH-1:0]      rem_final;

  // Operand conditioning and the single restoring subtract/shift step.
  always_comb begin
    go         = (bus.start_i == DivStart) && !bus.annul_i;
    op1_neg    = bus.signed_div_i && bus.opdata1_i[WIDTH-1];
    op2_neg    = bus.signed_div_i && bus.opdata2_i[WIDTH-1];
    op1_abs    = neg_if(bus.opdata1_i, op1_neg);
    op2_abs    = neg_if(bus.opdata2_i, op2_neg);
    trial      = {1'b0, dividend_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};
    step       = trial[WIDTH] ? {dividend_q[2*WIDTH-1:0], 1'b0}
                              : {trial[WIDTH-1:0], dividend_q[WIDTH-1:0], 1'b1};
    cnt_done   = (cnt_q == CntW'(WIDTH));
    quot_final = neg_if(dividend_q[WIDTH-1:0], neg_quot_q);
    rem_final  = neg_if(dividend_q[2*WIDTH:WIDTH+1], neg_rem_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DivFree: begin
        if (go) begin
          state_d = (bus.opdata2_i == ZeroWord) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        state_d = bus.annul_i ? DivFree : DivEnd;
      end
      DivOn: begin
        if (bus.annul_i) begin
          state_d = DivFree;
        end else if (cnt_done) begin
          state_d = DivEnd;
        end
      end
      DivEnd: begin
        // Annul while finished is treated exactly like the EX stage letting go.
        if ((bus.start_i == DivStop) || bus.annul_i) begin
          state_d = DivFree;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    unique case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (go && (bus.opdata2_i != ZeroWord)) begin
          cnt_d      = '0;
          dividend_d = {{WIDTH{1'b0}}, op1_abs, 1'b0};
          divisor_d  = op2_abs;
          neg_quot_d = op1_neg ^ op2_neg;
          neg_rem_d  = op1_neg;
        end
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = bus.annul_i ? DivResultNotReady : DivResultReady;
      end
      DivOn: begin
        if (bus.annul_i) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (!cnt_done) begin
          dividend_d = step;
          cnt_d      = cnt_q + CntW'(1);
        end else begin
          result_d = {rem_final, quot_final};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        if ((bus.start_i == DivStop) || bus.annul_i) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// Directed bench for div: a transaction-level model predicts ready/result each
// cycle, and directed vectors pin latency and hand-computed results.
`default_nettype none

module tb_div;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_if #(.WIDTH(32)) bus ();

  div #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: truncating division on magnitudes, then signs.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic        na, nb;
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) return 64'd0;
    na = s && a[31];
    nb = s && b[31];
    ua = na ? (32'd0 - a) : a;
    ub = nb ? (32'd0 - b) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (na ^ nb) q = 32'd0 - q;
    if (na) r = 32'd0 - r;
    return {r, q};
  endfunction

  // Model: an accepted request finishes 33 edges later (1 for a zero divisor),
  // is dropped by annul while busy, and is released once start falls.
  int          m_rem   = 0;
  logic        m_busy  = 1'b0;
  logic        m_ready = 1'b0;
  logic [63:0] m_res   = 64'd0;
  logic [63:0] m_pend  = 64'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rem = 0; m_busy = 1'b0; m_ready = 1'b0; m_res = 64'd0;
    end else if (m_ready) begin
      if (!bus.start_i || bus.annul_i) begin
        m_ready = 1'b0; m_res = 64'd0;
      end
    end else if (m_busy) begin
      if (bus.annul_i) begin
        m_busy = 1'b0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0; m_ready = 1'b1; m_res = m_pend;
        end
      end
    end else if (bus.start_i && !bus.annul_i) begin
      m_busy = 1'b1;
      m_rem  = (bus.opdata2_i == 32'd0) ? 1 : 33;
      m_pend = ref_div(bus.opdata1_i, bus.opdata2_i, bus.signed_div_i);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("cmp ready", {63'd0, bus.ready_o}, {63'd0, m_ready});
      chk("cmp result", bus.result_o, m_res);
    end
  end

  task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] er, input logic [31:0] eq,
                        input int lat);
    int   n;
    logic got;
    @(negedge clk);
    bus.opdata1_i = a; bus.opdata2_i = b; bus.signed_div_i = s; bus.start_i = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (bus.ready_o) got = 1'b1;
    end
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " result"}, bus.result_o, {er, eq});
    // Operands wiggling outside FREE must not disturb the held result.
    bus.opdata1_i = 32'hDEADBEEF; bus.opdata2_i = 32'd0;
    @(posedge clk); @(negedge clk);
    chk({name, " hold ready"}, {63'd0, bus.ready_o}, 64'd1);
    chk({name, " hold result"}, bus.result_o, {er, eq});
    bus.start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({name, " drop ready"}, {63'd0, bus.ready_o}, 64'd0);
    chk({name, " drop result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd0; bus.opdata2_i = 32'd0;
    bus.start_i = 1'b0; bus.annul_i = 1'b0;

    chk("model 100/7",  ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    chk("model -7/2",   ref_div(32'hFFFFFFF9, 32'd2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("model 7/-2",   ref_div(32'd7, 32'hFFFFFFFE, 1'b1), {32'd1, 32'hFFFFFFFD});
    chk("model ovf",    ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'd0, 32'h80000000});

    #1;
    chk("reset ready",  {63'd0, bus.ready_o}, 64'd0);
    chk("reset result", bus.result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_div("udiv 100/7", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 34);
    do_div("sdiv -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    do_div("sdiv 7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, 32'hFFFFFFFD, 34);
    do_div("div by zero", 32'h12345678, 32'd0, 1'b0, 32'd0, 32'd0, 2);
    do_div("sdiv ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, 34);
    do_div("udiv max/1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 32'hFFFFFFFF, 34);

    // Abort at cycle 10, restart at cycle 12.
    @(negedge clk);
    bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7; bus.signed_div_i = 1'b0;
    bus.start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
    end
    bus.annul_i = 1'b1; bus.start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.annul_i = 1'b0;
    chk("annul ready", {63'd0, bus.ready_o}, 64'd0);
    do_div("after annul 9/3", 32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 34);

    // Asynchronous reset in the middle of cycle 20.
    @(negedge clk);
    bus.opdata1_i = 32'd12345; bus.opdata2_i = 32'd11; bus.start_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    chk("midop reset ready",  {63'd0, bus.ready_o}, 64'd0);
    chk("midop reset result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_div("post reset 1000/10", 32'd1000, 32'd10, 1'b0, 32'd0, 32'd100, 34);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

`default_nettype wire
